// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port memory. Each transaction
// takes IDLE -> ACCESS -> RESP; a locking port may keep ownership for up to
// MAX_BURST consecutive grants while the other port waits.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p0_wen,
    input  logic          p0_lock,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic          p1_wen,
    input  logic          p1_lock,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          grant_id
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q;      // owner of the most recent grant; 1 after reset so port 0 wins the first tie
    logic            grant_q;     // visible owner; 0 after reset
    logic [BW-1:0]   burst_q, burst_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;
    logic            wen_q;
    logic [DW-1:0]   p0_rdata_q, p1_rdata_q;
    logic            grant_en;
    logic            win;
    logic            last_lock;

    // Next-state decode and winner selection for the grant taken in IDLE.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        win       = 1'b0;
        burst_d   = burst_q;
        last_lock = last_q ? p1_lock : p0_lock;

        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d  = ACCESS;
                    grant_en = 1'b1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A lone requester always wins; a tie honours a live lock of the last
        // owner until its burst budget is spent, otherwise it alternates.
        if (p0_req && p1_req) begin
            win = (last_lock && (burst_q < MAX_B)) ? last_q : ~last_q;
        end else begin
            win = p1_req;
        end

        if (win == last_q) begin
            burst_d = (burst_q == MAX_B) ? burst_q : burst_q + BW'(1);
        end else begin
            burst_d = BW'(1);
        end
    end

    // State register, grant bookkeeping, memory-side latches and read capture.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            burst_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            wen_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                last_q  <= win;
                grant_q <= win;
                burst_q <= burst_d;
                addr_q  <= win ? p1_addr  : p0_addr;
                din_q   <= win ? p1_wdata : p0_wdata;
                wen_q   <= win ? p1_wen   : p0_wen;
            end
            // Read data is captured at the edge that ends ACCESS, into the owner only.
            if (state_q == ACCESS && !wen_q) begin
                if (grant_q) p1_rdata_q <= mem_dout;
                else         p0_rdata_q <= mem_dout;
            end
        end
    end

    // Outputs decoded from the state register so a write still strobes even if
    // reset arrives at the edge that ends ACCESS.
    assign mem_wen  = (state_q == ACCESS) && wen_q;
    assign p0_ack   = (state_q == RESP) && !grant_q;
    assign p1_ack   = (state_q == RESP) &&  grant_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_wen = 1'b0, p1_wen = 1'b0;
    logic          p0_lock = 1'b0, p1_lock = 1'b0;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wen;
    logic [DW-1:0] mem_dout;
    logic          busy;
    logic          grant_id;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wen(p0_wen),
        .p0_lock(p0_lock), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wen(p1_wen),
        .p1_lock(p1_lock), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Environment memory: 256 words, combinational read, write on the edge.
    logic [DW-1:0] mem [256];
    logic          bd_we = 1'b0;
    logic [7:0]    bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    assign mem_dout = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_wen)    mem[mem_addr[7:0]] <= mem_din;
        else if (bd_we) mem[bd_addr]       <= bd_data;
    end

    // Requester protocol monitor: req must not fall before its ack.
    logic p0_req_s = 1'b0, p1_req_s = 1'b0;
    int   proto_viol = 0;
    always @(posedge clk) begin
        if (rst) begin
            proto_viol <= proto_viol + int'(p0_req_s && !p0_req && !p0_ack)
                                     + int'(p1_req_s && !p1_req && !p1_ack);
        end
        p0_req_s <= p0_req;
        p1_req_s <= p1_req;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_rd [2];
    int            m_last;
    int            m_burst;
    int            checks = 0;
    int            errors = 0;
    int            w;
    int            lock_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int            cont_exp [4]  = '{0, 1, 0, 1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last    = 1;
        m_burst   = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // One arbitration opportunity starting in IDLE. Returns the winner, or -1
    // when nobody requested. With keep=0 the winner drops req during RESP.
    task automatic slot(output int winner, input bit keep);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
        bit            lk;
        if (!p0_req && !p1_req) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_wen",  32'(mem_wen), 32'd0);
            winner = -1;
            return;
        end
        lk = (m_last == 1) ? p1_lock : p0_lock;
        if (p0_req && p1_req) winner = (lk && m_burst < MAX_BURST) ? m_last : 1 - m_last;
        else                  winner = p1_req ? 1 : 0;
        m_burst = (winner == m_last) ? ((m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST) : 1;
        m_last  = winner;
        a  = winner ? p1_addr  : p0_addr;
        d  = winner ? p1_wdata : p0_wdata;
        we = winner ? p1_wen   : p0_wen;

        tick(); // ACCESS
        chk("acc_busy",  32'(busy), 32'd1);
        chk("acc_grant", 32'(grant_id), 32'(winner));
        chk("acc_wen",   32'(mem_wen), 32'(we));
        chk("acc_addr",  mem_addr, a);
        chk("acc_din",   mem_din, d);
        chk("acc_ack",   32'({p1_ack, p0_ack}), 32'd0);
        if (we) ref_mem[a[7:0]] = d;
        else    exp_rd[winner]  = ref_mem[a[7:0]];

        tick(); // RESP
        chk("resp_ack",  32'({p1_ack, p0_ack}), (winner == 1) ? 32'd2 : 32'd1);
        chk("resp_wen",  32'(mem_wen), 32'd0);
        chk("resp_busy", 32'(busy), 32'd1);
        chk("resp_rd0",  p0_rdata, exp_rd[0]);
        chk("resp_rd1",  p1_rdata, exp_rd[1]);
        if (!keep) begin
            if (winner == 1) p1_req = 1'b0;
            else             p0_req = 1'b0;
        end

        tick(); // IDLE
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ack",  32'({p1_ack, p0_ack}), 32'd0);
        chk("end_wen",  32'(mem_wen), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 && (p0_req || p1_req); i++) slot(w, 1'b0);
        chk("drained", 32'({p1_req, p0_req}), 32'd0);
    endtask

    initial begin
        // Reset with memory preload through the back door.
        model_reset();
        bd_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bd_addr    = 8'(i);
            bd_data    = (i == 'h10) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = bd_data;
            tick();
        end
        bd_we = 1'b0;
        chk("rst_ack",   32'({p1_ack, p0_ack}), 32'd0);
        chk("rst_rd0",   p0_rdata, 32'd0);
        chk("rst_rd1",   p1_rdata, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_din",   mem_din, 32'd0);
        chk("rst_wen",   32'(mem_wen), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        rst = 1'b1;

        // Single read by p0.
        p0_addr = 32'h10; p0_wen = 1'b0; p0_req = 1'b1;
        slot(w, 1'b0);
        chk("single_win", 32'(w), 32'd0);
        chk("single_rd",  p0_rdata, 32'hDEADBEEF);

        // p1 write, then p0 reads it back; p1_rdata untouched.
        p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_wen = 1'b1; p1_req = 1'b1;
        slot(w, 1'b0);
        chk("wr_win", 32'(w), 32'd1);
        p0_addr = 32'h20; p0_wen = 1'b0; p0_req = 1'b1;
        slot(w, 1'b0);
        chk("xrd_p0", p0_rdata, 32'h12345678);
        chk("xrd_p1", p1_rdata, 32'd0);

        // Plain contention after reset: strict alternation.
        rst = 1'b0; tick(); rst = 1'b1; model_reset();
        p0_addr = 32'h10; p1_addr = 32'h20; p0_wen = 1'b0; p1_wen = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            slot(w, 1'b1);
            chk($sformatf("cont_%0d", i), 32'(w), 32'(cont_exp[i]));
        end
        drain();

        // Lock burst after reset.
        rst = 1'b0; tick(); rst = 1'b1; model_reset();
        p0_lock = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            slot(w, 1'b1);
            chk($sformatf("lock_%0d", i), 32'(w), 32'(lock_exp[i]));
        end
        p0_lock = 1'b0;
        drain();

        // Reset during RESP of a p0 read.
        p0_addr = 32'h10; p0_wen = 1'b0; p0_req = 1'b1;
        tick();
        chk("rr_grant", 32'(grant_id), 32'd0);
        tick();
        chk("rr_ack_before", 32'(p0_ack), 32'd1);
        rst = 1'b0; p0_req = 1'b0;
        tick();
        chk("rr_ack",   32'(p0_ack), 32'd0);
        chk("rr_busy",  32'(busy), 32'd0);
        chk("rr_grant0", 32'(grant_id), 32'd0);
        chk("rr_rd0",   p0_rdata, 32'd0);
        rst = 1'b1; model_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        slot(w, 1'b0);
        chk("rr_tie", 32'(w), 32'd0);
        drain();

        // Reset at the edge ending ACCESS of a write: the write still lands.
        p1_addr = 32'h30; p1_wdata = 32'hCAFEF00D; p1_wen = 1'b1; p1_req = 1'b1;
        tick();
        chk("rw_wen", 32'(mem_wen), 32'd1);
        rst = 1'b0; p1_req = 1'b0;
        tick();
        chk("rw_commit", mem[8'h30], 32'hCAFEF00D);
        chk("rw_noack",  32'({p1_ack, p0_ack}), 32'd0);
        chk("rw_busy",   32'(busy), 32'd0);
        ref_mem[8'h30] = 32'hCAFEF00D;
        rst = 1'b1; model_reset();

        // Ten idle cycles straight after reset.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idl_wen",  32'(mem_wen), 32'd0);
            chk("idl_busy", 32'(busy), 32'd0);
            chk("idl_ack",  32'({p1_ack, p0_ack}), 32'd0);
            chk("idl_addr", mem_addr, 32'd0);
        end

        // Randomized traffic.
        for (int r = 0; r < 200; r++) begin
            if (!p0_req && $urandom_range(0, 3) != 0) begin
                p0_addr  = 32'($urandom_range(0, 255));
                p0_wdata = $urandom;
                p0_wen   = 1'($urandom_range(0, 1));
                p0_req   = 1'b1;
            end
            if (!p1_req && $urandom_range(0, 3) != 0) begin
                p1_addr  = 32'($urandom_range(0, 255));
                p1_wdata = $urandom;
                p1_wen   = 1'($urandom_range(0, 1));
                p1_req   = 1'b1;
            end
            p0_lock = 1'($urandom_range(0, 1));
            p1_lock = 1'($urandom_range(0, 1));
            slot(w, 1'b0);
        end
        p0_lock = 1'b0; p1_lock = 1'b0;
        drain();
        tick();

        chk("protocol", 32'(proto_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified memory between the CPU's memory port and a second requester: the program loader or debug/DMA port. It accepts word transactions (read or write) from either port and serializes them onto the memory's address/data/write-enable pins. It returns read data and a one-cycle acknowledge to the winning port. Arbitration is round-robin with a bounded lock (burst) option. It sits between the CPU's memory-address/data-in mux outputs and the memory instance.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, max consecutive grants to a locking port while the other port waits (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- p0_req / p1_req  input  1  transaction request, held until ack
- p0_addr / p1_addr  input  AW  word address, stable while req
- p0_wdata / p1_wdata  input  DW  write data, stable while req
- p0_wen / p1_wen  input  1  1 = write, 0 = read
- p0_lock / p1_lock  input  1  request priority for the next grant (burst)
- p0_ack / p1_ack  output  1  one-cycle completion pulse
- p0_rdata / p1_rdata  output  DW  read data, valid from ack, held until the next read completion on that port
- mem_addr  output  AW  to memory address
- mem_din  output  DW  to memory write data
- mem_wen  output  1  to memory write enable
- mem_dout  input  DW  memory read data (combinational from mem_addr)
- busy  output  1  transaction in ACCESS or RESP
- grant_id  output  1  current/last owner port

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when any req is high at the edge.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Winner selection (IDLE only, evaluated at the edge):
  - If only one port requests, that port wins.
  - If both request and the last owner has lock=1 and burst_cnt < MAX_BURST, the last owner wins.
  - Otherwise the port ≠ last owner wins (round-robin).
- On grant, register the owner's addr, wdata, and wen into mem_addr/mem_din/wen_q, and set grant_id = owner.
- burst_cnt (width clog2(MAX_BURST)+1):
  - Grant to the same port as last: burst_cnt+1, saturating at MAX_BURST.
  - Grant to the other port: burst_cnt=1.
- ACCESS: mem_wen = wen_q. The write commits at the ACCESS-ending edge. On a read, capture mem_dout into the owner's rdata at the same edge; the non-owner's rdata is unchanged.
- RESP: owner ack=1. The requester must drop req, or present its next transaction, by the edge ending RESP.
- mem_wen = 0 in IDLE and RESP. mem_addr and mem_din hold their last latched value.
- The arbiter never grants a port whose req is low; a locking port with req low forfeits its priority.

## Timing
- Reset (rst=0 at an edge): state=IDLE.
  - All outputs 0: ack, rdata, mem_addr, mem_din, mem_wen, busy, grant_id.
  - last owner = 1, so port 0 wins the first tie. burst_cnt = 0.
- Latency: req sampled at edge E0 (state IDLE) → ACCESS in cycle E0–E1, memory write/read at E1 → ack high in cycle E1–E2 → IDLE in cycle E2–E3.
  - Next grant is earliest at E3.
  - Throughput is 1 transaction per 3 cycles.
- mem_wen is high for exactly one cycle per write and never during a read.
- Both req rising in the same cycle is resolved by the selection rules above. There is no back-to-back grant without an intervening IDLE cycle.
- Reset mid-operation:
  - If rst=0 at the edge ending ACCESS, a pending write still commits, because mem_wen is decoded from the state register. No ack is issued; the requester must reissue.
  - If rst=0 during RESP, the ack is dropped the next cycle.
- A req that drops before ack is a protocol violation. Behaviour is undefined; the bench checks for it with an assertion.

## Test plan
- Single read: memory[0x10]=0xDEADBEEF; p0 read 0x10 at E0 → p0_ack high only in cycle E1–E2, p0_rdata=0xDEADBEEF, mem_wen=0 throughout, busy high for 2 cycles.
- Write then cross-port read: p1 writes 0x20=0x12345678 → mem_wen high exactly 1 cycle with mem_addr=0x20. Then p0 reads 0x20 → p0_rdata=0x12345678 and p1_rdata unchanged.
- Contention: both ports hold read requests continuously after reset → grant_id sequence 0,1,0,1; each ack 3 cycles apart.
- Lock burst: MAX_BURST=4, p0_lock=1, both requesting continuously → grants 0,0,0,0,1,0,0,0,0,1.
- Reset mid-transaction: rst=0 during RESP of a p0 read → p0_ack=0 the next cycle, busy=0, grant_id=0, p0_rdata=0, next tie goes to p0.
- Idle: no req for 10 cycles → mem_wen=0, busy=0, acks 0, mem_addr unchanged.
